fifo_wr_arbiter: RTL

Round-robin write-port arbiter that shares the single write port of the 8-bit synchronous FIFO between `NUM_REQ` producers. Each producer has a valid/ready handshake. The arbiter locks the grant to one producer for a burst of up to `MAX_BURST` beats, then rotates priority. It sits directly in front of the FIFO, driving its `wr_en`/`buf_in` and observing `buf_full`.

---
 rtl/fifo_wr_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the 8-bit FIFO: locks a producer for up to MAX_BURST beats.
// Optional per-requester beat counters are enabled by defining FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4,
    parameter int unsigned ID_W       = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            buf_full,
    output logic                            wr_en,
    output logic [DATA_WIDTH-1:0]           buf_in,
    output logic [ID_W-1:0]                 grant_id,
    output logic                            busy,
    output logic [7:0]                      beat_cnt
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic                            stat_clr,
    output logic [NUM_REQ*16-1:0]           stat_beats
`endif
);

    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] owner_q, owner_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]      beat_cnt_q, beat_cnt_d;

    logic [ID_W-1:0]       sel;
    logic [ID_W-1:0]       cur;
    logic [7:0]            beat_inc;
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] x);
        if (x == ID_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return x + 1'b1;
    endfunction

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // First valid requester scanning upward from rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        logic            found;
        int unsigned     idx;
        logic [ID_W-1:0] idx_id;
        sel   = rr_ptr_q;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx    = (32'(rr_ptr_q) + k) % NUM_REQ;
            idx_id = ID_W'(idx);
            if (!found && req_valid[idx_id]) begin
                sel   = idx_id;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        cur    = (state_q == StBurst) ? owner_q : sel;
        wr_en  = req_valid[cur] & ~buf_full;
        buf_in = data_arr[cur];
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = wr_en && (cur == ID_W'(i));
        end
    end

    assign beat_inc = beat_cnt_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            StIdle: begin
                // In IDLE, wr_en implies some requester is valid and sel points at it.
                if (wr_en) begin
                    owner_d    = sel;
                    beat_cnt_d = 8'd1;
                    if (MAX_BURST == 1) begin
                        rr_ptr_d = next_id(sel);
                    end else begin
                        state_d = StBurst;
                    end
                end
            end
            StBurst: begin
                if (!req_valid[owner_q]) begin
                    state_d    = StIdle;
                    rr_ptr_d   = next_id(owner_q);
                    beat_cnt_d = 8'd0;
                end else if (wr_en) begin
                    beat_cnt_d = beat_inc;
                    if (beat_inc == 8'(MAX_BURST)) begin
                        state_d    = StIdle;
                        rr_ptr_d   = next_id(owner_q);
                        beat_cnt_d = 8'd0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign grant_id = owner_q;
    assign busy     = (state_q == StBurst);
    assign beat_cnt = beat_cnt_q;

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] stat_q [NUM_REQ];

    // Clear takes priority over a same-cycle increment; counters saturate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) stat_q[i] <= 16'd0;
        end else if (stat_clr) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) stat_q[i] <= 16'd0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && (stat_q[i] != 16'hFFFF)) begin
                    stat_q[i] <= stat_q[i] + 16'd1;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
        assign stat_beats[i*16 +: 16] = stat_q[i];
    end
`endif

endmodule
